// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: IDLE -> PEND (exc raised) -> HANDLER (until eret).
// Define EXC_CTRL_IRQ_LATCH_EN to latch IRQ rising edges; by default IRQs are level-sensitive.
module exc_ctrl #(
  parameter int unsigned N_IRQ = 4,
  localparam int unsigned IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic             not_an_instr,
  input  logic             eret,
  input  logic             exc_ack,
  output logic             exc,
  output logic [3:0]       estatus,
  output logic [IDW-1:0]   irq_id,
  output logic [N_IRQ-1:0] ext_iack,
  output logic             in_handler
);

  typedef enum logic [1:0] {StIdle, StPend, StHandler} state_e;

  localparam logic [3:0] CauseNone = 4'b0000;
  localparam logic [3:0] CauseIrq  = 4'b0001;
  localparam logic [3:0] CauseOpc  = 4'b0010;

  state_e           state_q, state_d;
  logic [3:0]       estatus_q, estatus_d;
  logic [IDW-1:0]   irq_id_q, irq_id_d;
  logic [N_IRQ-1:0] iack_q, iack_d;
  logic [N_IRQ-1:0] req, hit;
  logic [IDW-1:0]   low_id;

`ifdef EXC_CTRL_IRQ_LATCH_EN
  logic [N_IRQ-1:0] irq_prev_q, pending_q, rise;

  // Include this cycle's edge so latched mode has the same 1-cycle latency as level mode.
  assign rise = irq & ~irq_prev_q;
  assign req  = pending_q | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq;
      pending_q  <= req & ~iack_d;
    end
  end
`else
  assign req = irq;
`endif

  assign hit = req & irq_en;

  // Lowest-index enabled request wins.
  always_comb begin
    low_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (hit[i]) low_id = IDW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    estatus_d = estatus_q;
    irq_id_d  = irq_id_q;
    iack_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (not_an_instr) begin
          state_d   = StPend;
          estatus_d = CauseOpc;
          irq_id_d  = '0;
        end else if (|hit) begin
          state_d   = StPend;
          estatus_d = CauseIrq;
          irq_id_d  = low_id;
        end
      end
      StPend: begin
        if (exc_ack) begin
          state_d = StHandler;
          if (estatus_q == CauseIrq) iack_d[irq_id_q] = 1'b1;
        end
      end
      StHandler: begin
        if (eret) begin
          state_d   = StIdle;
          estatus_d = CauseNone;
          irq_id_d  = '0;
        end
      end
      default: begin
        state_d   = StIdle;
        estatus_d = CauseNone;
        irq_id_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      estatus_q <= CauseNone;
      irq_id_q  <= '0;
      iack_q    <= '0;
    end else begin
      state_q   <= state_d;
      estatus_q <= estatus_d;
      irq_id_q  <= irq_id_d;
      iack_q    <= iack_d;
    end
  end

  assign exc        = (state_q == StPend);
  assign in_handler = (state_q == StHandler);
  assign estatus    = estatus_q;
  assign irq_id     = irq_id_q;
  assign ext_iack   = iack_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model.
module tb_exc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq, irq_en;
  logic       not_an_instr, eret, exc_ack;
  logic       exc;
  logic [3:0] estatus;
  logic [1:0] irq_id;
  logic [3:0] ext_iack;
  logic       in_handler;

  int total = 0;
  int bad   = 0;

  exc_ctrl #(.N_IRQ(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .irq_en       (irq_en),
    .not_an_instr (not_an_instr),
    .eret         (eret),
    .exc_ack      (exc_ack),
    .exc          (exc),
    .estatus      (estatus),
    .irq_id       (irq_id),
    .ext_iack     (ext_iack),
    .in_handler   (in_handler)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = waiting, 1 = exception requested, 2 = in handler.
  int         m_mode = 0;
  logic [3:0] m_cause = 4'd0;
  int         m_id = 0;
  logic [3:0] m_iack = 4'd0;
  logic [3:0] m_lat = 4'd0;
  logic [3:0] m_prev = 4'd0;

  task automatic model_update(input logic r, input logic [3:0] i, input logic [3:0] e,
                              input logic n, input logic er, input logic a);
    logic [3:0] rq, hit, new_iack;
    new_iack = 4'd0;
    if (r) begin
      m_mode = 0; m_cause = 4'd0; m_id = 0; m_lat = 4'd0; m_prev = 4'd0;
    end else begin
`ifdef EXC_CTRL_IRQ_LATCH_EN
      rq = m_lat | (i & ~m_prev);
`else
      rq = i;
`endif
      hit = rq & e;
      if (m_mode == 0) begin
        if (n) begin
          m_mode = 1; m_cause = 4'd2; m_id = 0;
        end else if (hit != 4'd0) begin
          m_mode = 1; m_cause = 4'd1;
          m_id = 3;
          for (int k = 3; k >= 0; k--) if (hit[k]) m_id = k;
        end
      end else if (m_mode == 1) begin
        if (a) begin
          m_mode = 2;
          if (m_cause == 4'd1) new_iack = 4'd1 << m_id;
        end
      end else if (er) begin
        m_mode = 0; m_cause = 4'd0; m_id = 0;
      end
      m_lat  = rq & ~new_iack;
      m_prev = i;
    end
    m_iack = new_iack;
  endtask

  task automatic expect_v(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_model(input string tag);
    expect_v({tag, ".exc"}, {7'd0, exc}, {7'd0, m_mode == 1});
    expect_v({tag, ".in_handler"}, {7'd0, in_handler}, {7'd0, m_mode == 2});
    expect_v({tag, ".estatus"}, {4'd0, estatus}, {4'd0, m_cause});
    expect_v({tag, ".irq_id"}, {6'd0, irq_id}, 8'(m_id));
    expect_v({tag, ".ext_iack"}, {4'd0, ext_iack}, {4'd0, m_iack});
  endtask

  // Apply inputs for one rising edge, then compare on the following falling edge.
  task automatic step(input string tag, input logic r, input logic [3:0] i, input logic [3:0] e,
                      input logic n, input logic er, input logic a);
    reset = r; irq = i; irq_en = e; not_an_instr = n; eret = er; exc_ack = a;
    model_update(r, i, e, n, er, a);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  logic [3:0] pulse_hold;

  initial begin
    reset = 1'b1; irq = 4'd0; irq_en = 4'hf; not_an_instr = 1'b0; eret = 1'b0; exc_ack = 1'b0;
    @(negedge clk);
    step("rst", 1, 4'd0, 4'hf, 0, 0, 0);
    expect_v("rst.exc", {7'd0, exc}, 8'd0);
    expect_v("rst.estatus", {4'd0, estatus}, 8'd0);

    // Invalid opcode
    step("opc.trig", 0, 4'd0, 4'hf, 1, 0, 0);
    expect_v("opc.exc", {7'd0, exc}, 8'd1);
    expect_v("opc.estatus", {4'd0, estatus}, 8'd2);
    step("opc.wait", 0, 4'd0, 4'hf, 0, 1, 0);
    step("opc.ack", 0, 4'd0, 4'hf, 0, 0, 1);
    expect_v("opc.ack.exc", {7'd0, exc}, 8'd0);
    expect_v("opc.ack.iack", {4'd0, ext_iack}, 8'd0);
    expect_v("opc.ack.inh", {7'd0, in_handler}, 8'd1);
    step("opc.eret", 0, 4'd0, 4'hf, 0, 1, 0);
    expect_v("opc.eret.estatus", {4'd0, estatus}, 8'd0);

    // Priority among IRQs
    step("pri.trig", 0, 4'b1010, 4'hf, 0, 0, 0);
    expect_v("pri.estatus", {4'd0, estatus}, 8'd1);
    expect_v("pri.id", {6'd0, irq_id}, 8'd1);
    step("pri.ack", 0, 4'b0000, 4'hf, 0, 0, 1);
    expect_v("pri.iack", {4'd0, ext_iack}, 8'b0010);
    step("pri.hold", 0, 4'b0000, 4'hf, 0, 0, 1);
    expect_v("pri.iack0", {4'd0, ext_iack}, 8'd0);
    step("pri.eret", 0, 4'b0000, 4'hf, 0, 1, 0);

    // Opcode beats simultaneous IRQ; IRQ serviced afterwards
`ifdef EXC_CTRL_IRQ_LATCH_EN
    pulse_hold = 4'b0000;
`else
    pulse_hold = 4'b0001;
`endif
    step("sim.trig", 0, 4'b0001, 4'hf, 1, 0, 0);
    expect_v("sim.estatus", {4'd0, estatus}, 8'd2);
    step("sim.ack", 0, pulse_hold, 4'hf, 0, 0, 1);
    step("sim.eret", 0, pulse_hold, 4'hf, 0, 1, 0);
    step("sim.irq", 0, pulse_hold, 4'hf, 0, 0, 0);
    expect_v("sim.irq.estatus", {4'd0, estatus}, 8'd1);
    expect_v("sim.irq.id", {6'd0, irq_id}, 8'd0);
    step("sim.ack2", 0, 4'd0, 4'hf, 0, 0, 1);
    step("sim.eret2", 0, 4'd0, 4'hf, 0, 1, 0);

    // Masking
    for (int k = 0; k < 10; k++) begin
      step("mask.hold", 0, 4'b0100, 4'b1011, 0, 0, 0);
      expect_v("mask.exc", {7'd0, exc}, 8'd0);
    end
    step("mask.en", 0, 4'b0100, 4'b1111, 0, 0, 0);
    expect_v("mask.en.exc", {7'd0, exc}, 8'd1);
    expect_v("mask.en.id", {6'd0, irq_id}, 8'd2);
    step("mask.ack", 0, 4'd0, 4'hf, 0, 0, 1);
    step("mask.eret", 0, 4'd0, 4'hf, 0, 1, 0);

    // No nesting
    step("nest.trig", 0, 4'd0, 4'hf, 1, 0, 0);
    step("nest.ack", 0, 4'd0, 4'hf, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step("nest.irq", 0, 4'b0001, 4'hf, 0, 0, 0);
      expect_v("nest.exc", {7'd0, exc}, 8'd0);
    end
    step("nest.eret", 0, 4'b0001, 4'hf, 0, 1, 0);
    expect_v("nest.eret.exc", {7'd0, exc}, 8'd0);
    step("nest.re", 0, 4'b0001, 4'hf, 0, 0, 0);
    expect_v("nest.re.exc", {7'd0, exc}, 8'd1);
    step("nest.ack2", 0, 4'd0, 4'hf, 0, 0, 1);
    step("nest.eret2", 0, 4'd0, 4'hf, 0, 1, 0);

    // Reset while pending; stale ack afterwards
    step("rp.trig", 0, 4'b0001, 4'hf, 0, 0, 0);
    expect_v("rp.estatus", {4'd0, estatus}, 8'd1);
    step("rp.rst", 1, 4'd0, 4'hf, 0, 0, 1);
    expect_v("rp.rst.exc", {7'd0, exc}, 8'd0);
    expect_v("rp.rst.estatus", {4'd0, estatus}, 8'd0);
    step("rp.stale", 0, 4'd0, 4'hf, 0, 0, 1);
    expect_v("rp.stale.inh", {7'd0, in_handler}, 8'd0);
    expect_v("rp.stale.exc", {7'd0, exc}, 8'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(39) == 0), 4'($urandom), 4'($urandom),
           ($urandom_range(7) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
